test_access_ctrl: RTL and testbench
===================================

TEST_ACCESS_CTRL -- requirements
Module: test_access_ctrl

Interface
REQ-001 The block SHALL have parameter N_CH, default 8, giving the number of observed channels.
REQ-002 The block SHALL have parameter DATA_W, default 4, giving the bits per channel.
REQ-003 The block SHALL have parameter N_OUT, default 2, giving the number of observe output ports.
REQ-004 The block SHALL have parameter DEPTH, default 16, giving the capture buffer depth in samples (power of 2).
REQ-005 The block SHALL derive SEL_W = clog2(N_CH) and CFG_W = 2 + N_OUT*SEL_W + 4.
REQ-006 inClock  in  1  sole clock; all logic on its rising edge.
REQ-007 inReset  in  1  reset, synchronous, active-low.
REQ-008 inCfgShift  in  1  shifts the configuration chain one bit.
REQ-009 inCfgData  in  1  serial configuration bit, LSB first.
REQ-010 inCfgUpdate  in  1  loads the shift chain into the active configuration.
REQ-011 inObsData  in  N_CH*DATA_W  observed bus; channel k at [k*DATA_W +: DATA_W].
REQ-012 inTrigger  in  1  capture trigger, rising-edge sensitive.
REQ-013 inReadEnable  in  1  pops one capture sample.
REQ-014 outCfgData  out  1  chain output, equal to chain bit 0.
REQ-015 outObsData  out  N_OUT*DATA_W  live observe ports; port j at [j*DATA_W +: DATA_W].
REQ-016 outCapData  out  DATA_W  registered readback sample.
REQ-017 outCapEmpty  out  1  capture buffer holds no unread samples.
REQ-018 outCapDone  out  1  capture buffer full; readout allowed.
REQ-019 outBusy  out  1  FSM is in ARMED or CAPTURE.

Function
REQ-020 The configuration word SHALL be laid out as: [1:0] mode, then sel_j at [2+j*SEL_W +: SEL_W], then decim[3:0] in the top 4 bits.
REQ-021 While inCfgShift=1, the chain SHALL update as chain <= {inCfgData, chain[CFG_W-1:1]}.
REQ-022 When inCfgUpdate=1, the active configuration SHALL take the value of the chain (post-shift value if inCfgShift is also 1), effective from the next cycle.
REQ-023 Mode 00 OFF: outObsData SHALL be 0. Mode 11 (reserved) SHALL behave as OFF.
REQ-024 Mode 01 LIVE: port j SHALL register channel sel_j with 1-cycle latency; sel_j >= N_CH SHALL yield 0.
REQ-025 Mode 10 CAPTURE: outObsData SHALL behave as in LIVE, and the capture source SHALL be channel sel_0.
REQ-026 The FSM SHALL have states IDLE, ARMED, CAPTURE and READOUT.
REQ-027 IDLE->ARMED when the active mode is CAPTURE.
REQ-028 ARMED->CAPTURE on a detected rising edge of inTrigger, where edge = inTrigger & ~previous-cycle inTrigger.
REQ-029 In CAPTURE, the block SHALL write one sample on the edge cycle, then one every decim+1 cycles.
REQ-030 CAPTURE->READOUT after DEPTH writes; outCapDone SHALL be 1 throughout READOUT.
REQ-031 In READOUT, inReadEnable with outCapEmpty=0 SHALL pop the oldest sample; outCapData SHALL be valid the next cycle and hold until the next pop.
REQ-032 inReadEnable SHALL be ignored when outCapEmpty=1 or when the FSM is not in READOUT.
REQ-033 READOUT->ARMED when the last sample is popped and the mode is still CAPTURE; otherwise READOUT->IDLE.
REQ-034 Trigger edges outside ARMED SHALL be ignored.
REQ-035 inCfgUpdate in any state other than IDLE SHALL abort: FSM -> IDLE, buffer count and pointers cleared, new configuration applied.
REQ-036 Any mode other than CAPTURE SHALL force the FSM to IDLE on the next cycle.

Reset
REQ-037 While inReset=0 at a clock edge, the block SHALL clear chain, active configuration, FSM (IDLE), pointers, count, decimation counter and trigger history.
REQ-038 Reset values SHALL be: outObsData=0, outCapData=0, outCfgData=0, outCapEmpty=1, outCapDone=0, outBusy=0.
REQ-039 Reset asserted mid-capture SHALL discard all captured data.

Structure
REQ-040 Package test_access_pkg SHALL hold the mode enum (OFF, LIVE, CAPTURE, RSVD), the FSM state enum, and the configuration field offset functions.
REQ-041 Sub-module tac_capture_buf SHALL implement the DEPTH x DATA_W buffer: write/read pointers, count, empty/full flags, registered read data.

Verification (N_CH=8, DATA_W=4, N_OUT=2, DEPTH=16, CFG_W=12)
REQ-042 Reset: shift 12 ones with inReset=0 -> all outputs hold reset values; chain remains 0.
REQ-043 LIVE: shift cfg 0x0A9 (mode 01, sel0=2, sel1=5, decim=0) then update; channel2=0x7 and channel5=0xC -> outObsData=0xC7 one cycle after the update takes effect.
REQ-044 CAPTURE: cfg 0x30A (mode 10, sel0=2, decim=3) with channel2 counting 0..F each cycle; pulse inTrigger -> 16 samples spaced 4 apart (0,4,8,C,0,...), outCapDone=1; 16 pops return the same sequence, then outCapEmpty=1 and the FSM returns to ARMED.
REQ-045 Boundary: 17th pop -> outCapData unchanged; trigger held high for 20 cycles -> exactly one capture; trigger during CAPTURE -> no effect.
REQ-046 Abort: inCfgUpdate after 5 captured samples -> outBusy=0 next cycle, outCapEmpty=1.
REQ-047 Chain pass-through: shift 24 bits -> outCfgData reproduces the first 12 bits, delayed by 12 shifts; sel0=7 with N_CH=6 -> port 0 reads 0.

Source files
------------

// File: rtl/test_access_pkg.sv
// Shared types and configuration-word layout helpers for the test access
// controller.
//   mode_e   : observe/capture operating mode held in cfg[1:0]
//   state_e  : capture sequencer states
//   sel_lsb  : bit offset of the channel select for observe port j
//   decim_lsb: bit offset of the 4-bit decimation field
//   cfg_width: total configuration chain length
package test_access_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'b00,
      MODE_LIVE    = 2'b01,
      MODE_CAPTURE = 2'b10,
      MODE_RSVD    = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_READOUT = 2'd3
   } state_e;

   localparam int MODE_W  = 2;
   localparam int DECIM_W = 4;

   function automatic int sel_lsb(input int j, input int sel_w);
      return MODE_W + j * sel_w;
   endfunction

   function automatic int decim_lsb(input int n_out, input int sel_w);
      return MODE_W + n_out * sel_w;
   endfunction

   function automatic int cfg_width(input int n_out, input int sel_w);
      return MODE_W + n_out * sel_w + DECIM_W;
   endfunction

endpackage

// File: rtl/tac_capture_buf.sv
// Capture sample buffer: DEPTH x DATA_W circular store with registered
// readback.
//   clk_sys, rst_b : clock, synchronous active-low reset
//   clr            : synchronous clear of pointers and count (contents kept)
//   wr_en, wr_data : push one sample (ignored when full)
//   rd_en          : pop oldest sample into rd_data (ignored when empty)
//   rd_data        : last popped sample, held until the next pop
//   empty, count   : occupancy status
module tac_capture_buf #(
   parameter  int DEPTH  = 16,
   parameter  int DATA_W = 4,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = PTR_W + 1
) (
   input  logic              clk_sys,
   input  logic              rst_b,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              full;
   logic              do_wr;
   logic              do_rd;

   always_comb begin
      full      = (count_q == CNT_W'(DEPTH));
      empty     = (count_q == '0);
      do_wr     = wr_en & ~full & ~clr;
      do_rd     = rd_en & ~empty & ~clr;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      rd_data_d = rd_data_q;
      if (do_wr) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_rd) begin
         rd_ptr_d  = rd_ptr_q + PTR_W'(1);
         rd_data_d = mem_q[rd_ptr_q];
      end
      case ({do_wr, do_rd})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk_sys) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data = rd_data_q;
   assign count   = count_q;

endmodule

// File: rtl/test_access_ctrl.sv
// Test access controller: serial configuration chain, live channel observe
// mux and triggered, decimated capture of one channel into a readback buffer.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no capture activity; waits for mode CAPTURE
//   ST_ARMED   | waiting for a rising edge on inTrigger
//   ST_CAPTURE | storing channel sel_0 every decim+1 cycles until full
//   ST_READOUT | buffer full; inReadEnable pops samples oldest first
//
// Ports:
//   inClock, inReset         : clock, synchronous active-low reset
//   inCfgShift/Data/Update   : serial config chain (LSB first) and load
//   outCfgData               : chain bit 0
//   inObsData                : N_CH channels of DATA_W bits
//   outObsData               : N_OUT registered observe ports
//   inTrigger, inReadEnable  : capture start edge, sample pop
//   outCapData/Empty/Done    : readback sample and buffer status
//   outBusy                  : ARMED or CAPTURE
module test_access_ctrl
   import test_access_pkg::*;
#(
   parameter int N_CH   = 8,
   parameter int DATA_W = 4,
   parameter int N_OUT  = 2,
   parameter int DEPTH  = 16
) (
   input  logic                     inClock,
   input  logic                     inReset,
   input  logic                     inCfgShift,
   input  logic                     inCfgData,
   input  logic                     inCfgUpdate,
   input  logic [N_CH*DATA_W-1:0]   inObsData,
   input  logic                     inTrigger,
   input  logic                     inReadEnable,
   output logic                     outCfgData,
   output logic [N_OUT*DATA_W-1:0]  outObsData,
   output logic [DATA_W-1:0]        outCapData,
   output logic                     outCapEmpty,
   output logic                     outCapDone,
   output logic                     outBusy
);

   localparam int SEL_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CFG_W     = cfg_width(N_OUT, SEL_W);
   localparam int DECIM_LSB = decim_lsb(N_OUT, SEL_W);
   localparam int CNT_W     = $clog2(DEPTH) + 1;

   logic [CFG_W-1:0]        chain_q, chain_d;
   logic [CFG_W-1:0]        cfg_q, cfg_d;
   logic [N_OUT*DATA_W-1:0] obs_q, obs_d;
   state_e                  state_q, state_d;
   logic [DECIM_W-1:0]      dec_q, dec_d;
   logic                    trig_q;

   mode_e                   mode;
   logic [DECIM_W-1:0]      decim;
   logic                    trig_edge;
   logic                    buf_clr;
   logic                    buf_wr;
   logic                    buf_rd;
   logic [DATA_W-1:0]       buf_wr_data;
   logic                    buf_empty;
   logic [CNT_W-1:0]        buf_count;

   // Out-of-range selects read as zero.
   function automatic logic [DATA_W-1:0] pick(input logic [N_CH*DATA_W-1:0] bus,
                                              input logic [SEL_W-1:0] sel);
      logic [DATA_W-1:0] val;
      val = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (int'(sel) == k) val = bus[k*DATA_W +: DATA_W];
      end
      return val;
   endfunction

   assign mode        = mode_e'(cfg_q[1:0]);
   assign decim       = cfg_q[DECIM_LSB +: DECIM_W];
   assign trig_edge   = inTrigger & ~trig_q;
   assign buf_wr_data = pick(inObsData, cfg_q[sel_lsb(0, SEL_W) +: SEL_W]);

   // Update takes the post-shift chain so shift and update may coincide.
   always_comb begin
      chain_d = chain_q;
      if (inCfgShift) chain_d = {inCfgData, chain_q[CFG_W-1:1]};
      cfg_d = inCfgUpdate ? chain_d : cfg_q;
   end

   always_comb begin
      obs_d = '0;
      if (mode == MODE_LIVE || mode == MODE_CAPTURE) begin
         for (int j = 0; j < N_OUT; j++) begin
            obs_d[j*DATA_W +: DATA_W] = pick(inObsData, cfg_q[sel_lsb(j, SEL_W) +: SEL_W]);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      dec_d   = dec_q;
      buf_wr  = 1'b0;
      buf_rd  = 1'b0;
      buf_clr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mode == MODE_CAPTURE) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (trig_edge) begin
               buf_wr  = 1'b1;
               dec_d   = decim;
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (dec_q == '0) begin
               buf_wr = 1'b1;
               dec_d  = decim;
               if (buf_count == CNT_W'(DEPTH - 1)) state_d = ST_READOUT;
            end else begin
               dec_d = dec_q - DECIM_W'(1);
            end
         end
         ST_READOUT: begin
            if (inReadEnable && !buf_empty) begin
               buf_rd = 1'b1;
               if (buf_count == CNT_W'(1)) begin
                  state_d = (mode == MODE_CAPTURE) ? ST_ARMED : ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (mode != MODE_CAPTURE) state_d = ST_IDLE;
      // Reconfiguring mid-operation abandons the capture entirely.
      if (inCfgUpdate && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
         dec_d   = '0;
         buf_wr  = 1'b0;
         buf_rd  = 1'b0;
         buf_clr = 1'b1;
      end
   end

   always_ff @(posedge inClock) begin
      if (!inReset) begin
         chain_q <= '0;
         cfg_q   <= '0;
         obs_q   <= '0;
         state_q <= ST_IDLE;
         dec_q   <= '0;
         trig_q  <= 1'b0;
      end else begin
         chain_q <= chain_d;
         cfg_q   <= cfg_d;
         obs_q   <= obs_d;
         state_q <= state_d;
         dec_q   <= dec_d;
         trig_q  <= inTrigger;
      end
   end

   tac_capture_buf #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_buf (
      .clk_sys (inClock),
      .rst_b   (inReset),
      .clr     (buf_clr),
      .wr_en   (buf_wr),
      .wr_data (buf_wr_data),
      .rd_en   (buf_rd),
      .rd_data (outCapData),
      .empty   (buf_empty),
      .count   (buf_count)
   );

   assign outCfgData  = chain_q[0];
   assign outObsData  = obs_q;
   assign outCapEmpty = buf_empty;
   assign outCapDone  = (state_q == ST_READOUT);
   assign outBusy     = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);

endmodule

// File: tb/tb_test_access_ctrl.sv
// Directed bench for test_access_ctrl: default instance (N_CH=8) plus a
// six-channel instance for the out-of-range select case.
module tb_test_access_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        shift = 1'b0;
   logic        cdata = 1'b0;
   logic        upd = 1'b0;
   logic        trig = 1'b0;
   logic        rd = 1'b0;
   logic [3:0]  ch [8];
   logic        cnt_en = 1'b0;
   logic [3:0]  cnt2 = 4'h0;
   logic [31:0] obs;

   logic        a_cfg, a_empty, a_done, a_busy;
   logic [7:0]  a_obs;
   logic [3:0]  a_cap;
   logic        b_cfg, b_empty, b_done, b_busy;
   logic [7:0]  b_obs;
   logic [3:0]  b_cap;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cnt2 <= cnt2 + 4'h1;

   always_comb begin
      obs = '0;
      for (int k = 0; k < 8; k++) begin
         obs[k*4 +: 4] = (k == 2 && cnt_en) ? cnt2 : ch[k];
      end
   end

   test_access_ctrl dut_a (
      .inClock(clk), .inReset(rst), .inCfgShift(shift), .inCfgData(cdata),
      .inCfgUpdate(upd), .inObsData(obs), .inTrigger(trig), .inReadEnable(rd),
      .outCfgData(a_cfg), .outObsData(a_obs), .outCapData(a_cap),
      .outCapEmpty(a_empty), .outCapDone(a_done), .outBusy(a_busy)
   );

   test_access_ctrl #(.N_CH(6)) dut_b (
      .inClock(clk), .inReset(rst), .inCfgShift(shift), .inCfgData(cdata),
      .inCfgUpdate(upd), .inObsData(obs[23:0]), .inTrigger(trig), .inReadEnable(rd),
      .outCfgData(b_cfg), .outObsData(b_obs), .outCapData(b_cap),
      .outCapEmpty(b_empty), .outCapDone(b_done), .outBusy(b_busy)
   );

   // All stimulus tasks start and end just after a falling edge.
   task automatic shift_word(input logic [11:0] w);
      for (int i = 0; i < 12; i++) begin
         shift = 1'b1; cdata = w[i];
         @(negedge clk);
      end
      shift = 1'b0; cdata = 1'b0;
   endtask

   task automatic pulse_update();
      upd = 1'b1;
      @(negedge clk);
      upd = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      shift_word(12'hFFF);
      checks += 6;
      if (a_cfg !== 1'b0)   begin errors++; $display("FAIL reset_cfgdata got %b exp 0", a_cfg); end
      if (a_obs !== 8'h00)  begin errors++; $display("FAIL reset_obs got %h exp 00", a_obs); end
      if (a_cap !== 4'h0)   begin errors++; $display("FAIL reset_capdata got %h exp 0", a_cap); end
      if (a_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", a_empty); end
      if (a_done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b exp 0", a_done); end
      if (a_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b exp 0", a_busy); end
      rst = 1'b1;
      for (int i = 0; i < 12; i++) begin
         shift = 1'b1; cdata = 1'b0;
         @(negedge clk);
         checks++;
         if (a_cfg !== 1'b0) begin errors++; $display("FAIL reset_chain_zero shift %0d got %b exp 0", i, a_cfg); end
      end
      shift = 1'b0;
   endtask

   task automatic test_live();
      ch[2] = 4'h7; ch[5] = 4'hC; ch[7] = 4'h9;
      shift_word(12'h0A9);
      pulse_update();
      checks++;
      if (a_obs !== 8'h00) begin errors++; $display("FAIL live_latency got %h exp 00", a_obs); end
      @(negedge clk);
      checks += 2;
      if (a_obs !== 8'hC7) begin errors++; $display("FAIL live_obs got %h exp C7", a_obs); end
      if (a_busy !== 1'b0) begin errors++; $display("FAIL live_busy got %b exp 0", a_busy); end
      ch[2] = 4'h3;
      @(negedge clk);
      checks++;
      if (a_obs !== 8'hC3) begin errors++; $display("FAIL live_follow got %h exp C3", a_obs); end
   endtask

   task automatic test_sel_range();
      shift_word(12'h0BD);
      pulse_update();
      @(negedge clk);
      checks += 2;
      if (a_obs !== 8'hC9) begin errors++; $display("FAIL sel7_n8 got %h exp C9", a_obs); end
      if (b_obs !== 8'hC0) begin errors++; $display("FAIL sel7_n6 got %h exp C0", b_obs); end
      shift_word(12'h0AB);
      pulse_update();
      @(negedge clk);
      checks += 2;
      if (a_obs !== 8'h00) begin errors++; $display("FAIL mode_rsvd_obs got %h exp 00", a_obs); end
      if (a_busy !== 1'b0) begin errors++; $display("FAIL mode_rsvd_busy got %b exp 0", a_busy); end
   endtask

   task automatic test_chain();
      logic [23:0] pat;
      pat = 24'h5A3C96;
      for (int s = 0; s < 24; s++) begin
         shift = 1'b1; cdata = pat[s];
         @(negedge clk);
         if (s >= 11 && s <= 22) begin
            checks++;
            if (a_cfg !== pat[s-11]) begin
               errors++; $display("FAIL chain_passthru shift %0d got %b exp %b", s+1, a_cfg, pat[s-11]);
            end
         end
      end
      shift = 1'b0; cdata = 1'b0;
   endtask

   task automatic test_capture();
      logic [3:0] expv;
      cnt_en = 1'b1;
      shift_word(12'h30A);
      pulse_update();
      @(negedge clk);
      checks += 3;
      if (a_busy !== 1'b1)  begin errors++; $display("FAIL cap_armed_busy got %b exp 1", a_busy); end
      if (a_done !== 1'b0)  begin errors++; $display("FAIL cap_armed_done got %b exp 0", a_done); end
      if (a_empty !== 1'b1) begin errors++; $display("FAIL cap_armed_empty got %b exp 1", a_empty); end
      for (int c = 0; c < 20 && cnt2 !== 4'h0; c++) @(negedge clk);
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      repeat (9) @(negedge clk);
      trig = 1'b1;            // edge while capturing must be ignored
      @(negedge clk);
      trig = 1'b0;
      for (int c = 0; c < 100 && a_done !== 1'b1; c++) @(negedge clk);
      checks += 3;
      if (a_done !== 1'b1)  begin errors++; $display("FAIL cap_done got %b exp 1", a_done); end
      if (a_busy !== 1'b0)  begin errors++; $display("FAIL cap_done_busy got %b exp 0", a_busy); end
      if (a_empty !== 1'b0) begin errors++; $display("FAIL cap_done_empty got %b exp 0", a_empty); end
      rd = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         expv = 4'(i * 4);
         checks++;
         if (a_cap !== expv) begin errors++; $display("FAIL cap_pop %0d got %h exp %h", i, a_cap, expv); end
      end
      checks += 3;
      if (a_empty !== 1'b1) begin errors++; $display("FAIL cap_after_empty got %b exp 1", a_empty); end
      if (a_done !== 1'b0)  begin errors++; $display("FAIL cap_after_done got %b exp 0", a_done); end
      if (a_busy !== 1'b1)  begin errors++; $display("FAIL cap_rearmed got %b exp 1", a_busy); end
      @(negedge clk);         // 17th pop
      rd = 1'b0;
      checks++;
      if (a_cap !== 4'hC) begin errors++; $display("FAIL cap_pop17 got %h exp C", a_cap); end
   endtask

   task automatic test_trigger_held();
      logic [3:0] expv;
      shift_word(12'h00A);
      pulse_update();
      repeat (2) @(negedge clk);
      for (int c = 0; c < 20 && cnt2 !== 4'h5; c++) @(negedge clk);
      trig = 1'b1;
      for (int c = 0; c < 40 && a_done !== 1'b1; c++) @(negedge clk);
      checks++;
      if (a_done !== 1'b1) begin errors++; $display("FAIL held_done got %b exp 1", a_done); end
      rd = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         expv = 4'(5 + i);
         checks++;
         if (a_cap !== expv) begin errors++; $display("FAIL held_pop %0d got %h exp %h", i, a_cap, expv); end
      end
      rd = 1'b0;
      repeat (10) @(negedge clk);
      checks += 3;
      if (a_done !== 1'b0)  begin errors++; $display("FAIL held_second_done got %b exp 0", a_done); end
      if (a_empty !== 1'b1) begin errors++; $display("FAIL held_second_empty got %b exp 1", a_empty); end
      if (a_busy !== 1'b1)  begin errors++; $display("FAIL held_still_armed got %b exp 1", a_busy); end
      trig = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_abort();
      shift_word(12'h0A9);
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      repeat (4) @(negedge clk);
      checks += 2;
      if (a_empty !== 1'b0) begin errors++; $display("FAIL abort_pre_empty got %b exp 0", a_empty); end
      if (a_busy !== 1'b1)  begin errors++; $display("FAIL abort_pre_busy got %b exp 1", a_busy); end
      pulse_update();
      checks += 3;
      if (a_busy !== 1'b0)  begin errors++; $display("FAIL abort_busy got %b exp 0", a_busy); end
      if (a_empty !== 1'b1) begin errors++; $display("FAIL abort_empty got %b exp 1", a_empty); end
      if (a_done !== 1'b0)  begin errors++; $display("FAIL abort_done got %b exp 0", a_done); end
      @(negedge clk);
      checks++;
      if (a_busy !== 1'b0) begin errors++; $display("FAIL abort_live_idle got %b exp 0", a_busy); end
   endtask

   task automatic test_reset_mid_capture();
      shift_word(12'h30A);
      pulse_update();
      repeat (2) @(negedge clk);
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      checks += 4;
      if (a_busy !== 1'b0)  begin errors++; $display("FAIL rstcap_busy got %b exp 0", a_busy); end
      if (a_empty !== 1'b1) begin errors++; $display("FAIL rstcap_empty got %b exp 1", a_empty); end
      if (a_cap !== 4'h0)   begin errors++; $display("FAIL rstcap_capdata got %h exp 0", a_cap); end
      if (a_obs !== 8'h00)  begin errors++; $display("FAIL rstcap_obs got %h exp 00", a_obs); end
      repeat (2) @(negedge clk);
      checks++;
      if (a_busy !== 1'b0) begin errors++; $display("FAIL rstcap_stay_idle got %b exp 0", a_busy); end
   endtask

   initial begin
      for (int k = 0; k < 8; k++) ch[k] = 4'(k + 8);
      @(negedge clk);
      test_reset();
      test_live();
      test_sel_range();
      test_chain();
      test_capture();
      test_trigger_held();
      test_abort();
      test_reset_mid_capture();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
